// File: rtl/tick_rate_decoder.sv
// Measures the rising-edge spacing of a tick stream and decodes it back to the
// 2-bit speed code whose nominal period it matches within +/- TOL cycles.
//   state   | meaning
//   IDLE    | disabled, counter cleared
//   ARM     | waiting for the first edge of a measurement
//   MEASURE | counting cycles since the last edge
module tick_rate_decoder #(
  parameter int          CNT_W = 28,
  parameter int unsigned P0    = 2,
  parameter int unsigned P1    = 50000000,
  parameter int unsigned P2    = 100000000,
  parameter int unsigned P3    = 200000000,
  parameter int unsigned TOL   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period_out,
  output logic [1:0]       speed_out,
  output logic             match,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [1:0]       speed_q;
  logic             tick_q;
  logic             match_q;
  logic             valid_q;
  logic             timeout_q;

  logic             tick_rise;
  logic             hit;
  logic [1:0]       code;

  // Distance is taken one bit wider than the counter so |cnt - Pk| never wraps.
  function automatic logic near(input logic [CNT_W-1:0] c, input int unsigned p);
    logic [CNT_W:0] a;
    logic [CNT_W:0] b;
    logic [CNT_W:0] d;
    a = {1'b0, c};
    b = (CNT_W+1)'(p);
    d = (a >= b) ? (a - b) : (b - a);
    return d <= (CNT_W+1)'(TOL);
  endfunction

  assign tick_rise = tick_in & ~tick_q;

  always_comb begin
    hit  = 1'b1;
    code = 2'd0;
    if (near(cnt_q, P0))      code = 2'd0;
    else if (near(cnt_q, P1)) code = 2'd1;
    else if (near(cnt_q, P2)) code = 2'd2;
    else if (near(cnt_q, P3)) code = 2'd3;
    else                      hit  = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      speed_q   <= 2'b00;
      tick_q    <= 1'b0;
      match_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      tick_q  <= tick_in;
      valid_q <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
          end
          ARM: begin
            if (tick_rise) begin
              cnt_q   <= CNT_W'(1);
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (tick_rise) begin
              period_q  <= cnt_q;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              cnt_q     <= CNT_W'(1);
              if (hit) begin
                speed_q <= code;
                match_q <= 1'b1;
              end else begin
                match_q <= 1'b0;
              end
            end else if (cnt_q == CNT_MAX) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ARM;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period_out = period_q;
  assign speed_out  = speed_q;
  assign match      = match_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_tick_rate_decoder.sv
// Bench for tick_rate_decoder: stimulus pushes expected results into a queue,
// a negedge monitor pops one entry per valid pulse and compares.
module tb_tick_rate_decoder;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [1:0]       speed;
    logic             match;
    logic             timeout;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             tick_in;
  logic [CNT_W-1:0] period_out;
  logic [1:0]       speed_out;
  logic             match;
  logic             valid;
  logic             timeout;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  tick_rate_decoder #(
    .CNT_W(CNT_W), .P0(2), .P1(10), .P2(20), .P3(40), .TOL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tick_in(tick_in),
    .period_out(period_out), .speed_out(speed_out), .match(match),
    .valid(valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("period_out", int'(period_out), int'(e.period));
        check("speed_out", int'(speed_out), int'(e.speed));
        check("match", int'(match), int'(e.match));
        check("timeout_on_valid", int'(timeout), int'(e.timeout));
      end
    end
  end

  task automatic step(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
  endtask

  // Edge lands gap cycles after the previous edge cycle.
  task automatic send(input int gap);
    repeat (gap - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic expect_out(input int p, input int s, input int m);
    exp_t e;
    e.period  = CNT_W'(p);
    e.speed   = 2'(s);
    e.match   = 1'(m);
    e.timeout = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    int first_to;
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    enable  = 1'b0;
    tick_in = 1'b0;
    #23;
    check("rst_period", int'(period_out), 0);
    check("rst_valid_timeout_match", int'({valid, timeout, match}), 0);
    reset_n = 1'b1;
    step(1'b0);

    // back-to-back ticks at period 10
    enable = 1'b1;
    step(1'b0);
    send(3);
    repeat (4) begin
      expect_out(10, 1, 1);
      send(10);
    end

    // tolerance windows around 20
    expect_out(19, 2, 1); send(19);
    expect_out(21, 2, 1); send(21);
    expect_out(22, 2, 0); send(22);

    // fastest rate, then enable drop
    repeat (3) begin
      expect_out(2, 0, 1);
      send(2);
    end
    enable = 1'b0;
    step(1'b0); step(1'b0); step(1'b0);
    check("hold_period", int'(period_out), 2);
    check("hold_speed_match", int'({speed_out, match}), 1);
    check("hold_timeout", int'(timeout), 0);
    enable = 1'b1;
    step(1'b0);

    // single edge, then silence until saturation
    send(3);
    first_to = 0;
    for (int i = 1; i <= 300; i++) begin
      step(1'b0);
      if (timeout && first_to == 0) first_to = i;
    end
    check("timeout_cycle", first_to, 255);
    send(5);
    check("timeout_sticky_after_arm_edge", int'(timeout), 1);
    expect_out(40, 3, 1);
    send(40);
    step(1'b0);
    check("timeout_cleared", int'(timeout), 0);

    // edge coinciding with enable drop
    repeat (8) step(1'b0);
    enable = 1'b0;
    step(1'b1);
    check("collision_no_valid", int'(valid), 0);
    step(1'b0);
    check("collision_period_held", int'(period_out), 40);
    step(1'b0);
    enable = 1'b1;
    step(1'b0);
    send(4);
    expect_out(10, 1, 1);
    send(10);

    // edge exactly at saturation, then tick stuck high
    expect_out(255, 1, 0);
    send(255);
    repeat (260) step(1'b1);
    check("stuck_high_timeout", int'(timeout), 1);

    // reset mid-run with tick activity
    step(1'b0);
    send(3);
    send(10);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_period", int'(period_out), 0);
    check("midrst_flags", int'({speed_out, match, valid, timeout}), 0);
    // the period-10 edge right before reset never reaches valid
    expect_out(10, 1, 1);
    void'(exp_q.pop_back());
    #10;
    reset_n = 1'b1;
    step(1'b0);
    step(1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, expected completion");
    $fatal(1);
  end

endmodule
